// File: rtl/mem_stage_ctrl.sv
// MEM-stage data RAM controller: one load/store at a time, byte/half/word lanes, MEM_LAT latency.
// Optional macro MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of aligning them.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept;
  logic                write_q, signed_q, err_q;
  logic [AW+1:0]       addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                cur_write, cur_signed, misaligned;
  logic [AW+1:0]       cur_addr;
  logic [DATA_W-1:0]   cur_wdata, word_rd, lane, ext, load_val, wdata_sh, merged;
  logic [1:0]          cur_size, off;
  logic [3:0]          be;

  // In IDLE the request is still on the inputs; afterwards use the latched copy.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write  = req_write;
      cur_addr   = req_addr[AW+1:0];
      cur_wdata  = req_wdata;
      cur_size   = req_size;
      cur_signed = req_signed;
    end else begin
      cur_write  = write_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
      cur_size   = size_q;
      cur_signed = signed_q;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((cur_size == 2'b01) && cur_addr[0]) ||
                      (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    off = 2'b00;
    be  = 4'hf;
    case (cur_size)
      2'b00:   begin off = cur_addr[1:0];         be = 4'b0001 << cur_addr[1:0]; end
      2'b01:   begin off = {cur_addr[1], 1'b0};   be = 4'b0011 << {cur_addr[1], 1'b0}; end
      default: begin off = 2'b00;                 be = 4'hf; end
    endcase
  end

  assign word_rd  = mem_q[cur_addr[AW+1:2]];
  assign lane     = word_rd >> {off, 3'b000};
  assign wdata_sh = cur_wdata << {off, 3'b000};

  always_comb begin
    ext = lane;
    case (cur_size)
      2'b00:   ext = {{(DATA_W-8){cur_signed & lane[7]}}, lane[7:0]};
      2'b01:   ext = {{(DATA_W-16){cur_signed & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
    load_val = (cur_write || misaligned) ? '0 : ext;
  end

  always_comb begin
    merged = word_rd;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (MEM_LAT == 1) begin
            state_d = StResp;
          end else begin
            cnt_d   = CW'(MEM_LAT - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        addr_q   <= req_addr[AW+1:0];
        wdata_q  <= req_wdata;
        size_q   <= req_size;
      end
      // Result and error are captured on entry to RESP and then held.
      if (state_d == StResp) begin
        rdata_q <= load_val;
        err_q   <= misaligned;
      end
    end
  end

  // Store commits on the edge that ends RESP; a reset in flight never reaches here.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StResp) && write_q && !err_q) begin
      mem_q[addr_q[AW+1:2]] <= merged;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (DEPTH=256, MEM_LAT=2).
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl #(.DATA_W(32), .DEPTH(256), .MEM_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction with latency/handshake checks; returns at a negedge in IDLE.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    check({tag, ".ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_size   = sz;
    req_signed = sg;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".busy_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ".busy_ready"}, {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ".resp_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, ".pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ".rdata_hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = 2'b00; req_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'b0, req_ready}, 32'd1);
    check("rst.valid", {31'b0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;

    // Word store and load.
    access("st_w10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    access("ld_w10", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);
    // Byte lanes and extension.
    access("st_b12", 1, 32'h12, 32'h0000005A, 2'b00, 0, 32'h0, 0);
    access("ld_w10b", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDE5ABEEF, 0);
    access("ld_sb13", 0, 32'h13, 32'h0, 2'b00, 1, 32'hFFFFFFDE, 0);
    access("ld_ub13", 0, 32'h13, 32'h0, 2'b00, 0, 32'h000000DE, 0);
    access("ld_sb12", 0, 32'h12, 32'h0, 2'b00, 1, 32'h0000005A, 0);
    access("ld_sb10", 0, 32'h10, 32'h0, 2'b00, 1, 32'hFFFFFFEF, 0);
    access("ld_uh12", 0, 32'h12, 32'h0, 2'b01, 0, 32'h0000DE5A, 0);
    // Halfword store into upper half.
    access("st_w20", 1, 32'h20, 32'h11112222, 2'b10, 0, 32'h0, 0);
    access("st_h22", 1, 32'h22, 32'h00008001, 2'b01, 0, 32'h0, 0);
    access("ld_sh22", 0, 32'h22, 32'h0, 2'b01, 1, 32'hFFFF8001, 0);
    access("ld_uh22", 0, 32'h22, 32'h0, 2'b01, 0, 32'h00008001, 0);
    access("ld_w20", 0, 32'h20, 32'h0, 2'b10, 0, 32'h80012222, 0);
    // Address wrap modulo DEPTH*4.
    access("st_w400", 1, 32'h400, 32'h12345678, 2'b10, 0, 32'h0, 0);
    access("ld_w000", 0, 32'h000, 32'h0, 2'b10, 0, 32'h12345678, 0);
    // Reset aborts an in-flight store.
    access("st_w30z", 1, 32'h30, 32'h00000000, 2'b10, 0, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hFFFFFFFF; req_size = 2'b10; req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.valid_rst", {31'b0, resp_valid}, 32'd0);
    check("abort.ready_rst", {31'b0, req_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.no_resp", {31'b0, resp_valid}, 32'd0);
    end
    access("ld_w30a", 0, 32'h30, 32'h0, 2'b10, 0, 32'h00000000, 0);
    // Misaligned word store.
`ifdef MEM_MISALIGN_TRAP_EN
    access("st_w31", 1, 32'h31, 32'hCAFEF00D, 2'b10, 0, 32'h0, 1);
    access("ld_w30m", 0, 32'h30, 32'h0, 2'b10, 0, 32'h00000000, 0);
    access("ld_sh33", 0, 32'h33, 32'h0, 2'b01, 1, 32'h00000000, 1);
`else
    access("st_w31", 1, 32'h31, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0);
    access("ld_w30m", 0, 32'h30, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0);
    access("ld_sh33", 0, 32'h33, 32'h0, 2'b01, 1, 32'hFFFFCAFE, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised successor of the pipeline MEM stage: owns a word-organised data RAM and services one load/store at a time.
- Adds byte/halfword/word access with byte lanes, sign/zero extension, configurable multi-cycle latency, and a valid/ready handshake that stalls the pipeline.
- Sits between the EX/MEM and MEM/WB pipeline registers. The ALU result is the address and readData2 is the store data.

Parameters:
- DATA_W, 32, data width in bits; must be 32 in this generation (lane logic is fixed at 4 bytes).
- DEPTH, 256, number of DATA_W words in the RAM; must be a power of two.
- MEM_LAT, 2, cycles from request acceptance to resp_valid; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load (DataMemRW meaning)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (readData2), right-aligned
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- req_signed  in  1  sign-extend loads when 1
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load result, extended; 0 for stores
- resp_err  out  1  misalignment flag (see Optional Feature)

Behaviour:
- Reset values:
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - FSM goes to IDLE and the latency counter clears.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready = 1. When req_valid is high, latch addr/wdata/size/signed/write. If MEM_LAT == 1, go to RESP; otherwise load counter = MEM_LAT-1 and go to BUSY.
  - BUSY: req_ready = 0. Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: resp_valid = 1 for exactly one cycle and req_ready = 0. The write commits to RAM on this cycle's rising edge. Return to IDLE.
- Latency:
  - resp_valid rises MEM_LAT cycles after the accepting edge.
  - Back-to-back throughput is one request per MEM_LAT+1 cycles.
  - req_valid while req_ready = 0 is ignored; the requester must hold it.
- Indexing:
  - word index = req_addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = addr[1:0]; half lane = addr[1].
- Stores:
  - Byte stores write req_wdata[7:0] into lane addr[1:0].
  - Half stores write req_wdata[15:0] into half addr[1].
  - Word stores write all 32 bits.
  - Unselected lanes are unchanged (read-modify-write by byte enable).
- Loads:
  - The selected lane is shifted to bit 0.
  - Bits above the lane are filled with the lane MSB if req_signed = 1, otherwise with 0.
- Ordering: a load following a store to the same word observes the stored data, because the write commits before the next acceptance.
- Reset mid-operation: the access is aborted. A pending store is not committed, and no resp_valid is produced.
- resp_rdata holds its value until the next RESP; resp_err is meaningful only while resp_valid = 1.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, is misaligned.
  - Misaligned requests still take MEM_LAT cycles and assert resp_err = 1 with resp_valid.
  - Stores are suppressed (RAM unchanged) and resp_rdata = 0.
- Undefined:
  - resp_err is tied to 0.
  - Low address bits are forced to alignment (half ignores addr[0], word ignores addr[1:0]) and the access proceeds.

Test Plan:
1. Reset, then word store 0xDEADBEEF to 0x10, then word load 0x10 → resp_rdata = 0xDEADBEEF; resp_valid exactly 2 cycles after each accept (MEM_LAT = 2); req_ready low for 2 cycles per request.
2. After test 1, byte store 0x5A to 0x12, then word load 0x10 → 0xDE5ABEEF. Signed byte load 0x13 → 0xFFFFFFDE; unsigned byte load 0x13 → 0x000000DE.
3. Half store 0x8001 to 0x22, then signed half load 0x22 → 0xFFFF8001; unsigned → 0x00008001; word load 0x20 → upper half 0x8001, lower half unchanged.
4. With DEPTH = 256, word store 0x12345678 to 0x400, then word load 0x000 → 0x12345678 (wrap).
5. Assert rst one cycle after accepting a store of 0xFFFFFFFF to 0x30 (old value 0), then release and load 0x30 → 0x00000000; no resp_valid produced for the aborted store.
6. With MEM_MISALIGN_TRAP_EN defined, word store to 0x31 → resp_err = 1, RAM unchanged. Without the macro, the same store writes word 0x30 and resp_err = 0.
